// File: rtl/ac_motor_gate_guard.sv
// Final protection stage between the dead-time generators and the gate drivers:
// shoot-through interlock, minimum on-pulse filter, bootstrap precharge and latched fault.
module ac_motor_gate_guard #(
   parameter int unsigned MIN_ON     = 20,
   parameter int unsigned PRECHARGE  = 1000,
   parameter int unsigned FAULT_HOLD = 10000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       fault_in,
   input  logic       clear,
   input  logic [5:0] gate_in,
   output logic [5:0] gate_out,
   output logic [1:0] state,
   output logic       fault_latched,
   output logic       shoot_through
);

   typedef enum logic [1:0] {
      ST_OFF       = 2'd0,
      ST_PRECHARGE = 2'd1,
      ST_RUN       = 2'd2,
      ST_FAULT     = 2'd3
   } state_t;

   localparam logic [7:0]  QMAX      = 8'(MIN_ON);
   localparam logic [15:0] PRE_LOAD  = 16'(PRECHARGE - 1);
   localparam logic [15:0] HOLD_LOAD = 16'(FAULT_HOLD - 1);
   localparam logic [5:0]  LOW_SIDES = 6'b101010;

   state_t          st;
   logic [15:0]     cnt;
   logic [5:0][7:0] q;
   logic [5:0][7:0] q_next;
   logic [2:0]      conflict;
   logic [5:0]      run_gate;
   logic            stay_run;

   assign state    = st;
   assign stay_run = (st == ST_RUN) && enable && !fault_in;

   // Per phase: bit H is the high side, bit L the low side. The qualification
   // counters only ever delay turn-on; a low input clears its counter at once.
   for (genvar k = 0; k < 3; k++) begin : g_phase
      localparam int H = 2 * k;
      localparam int L = 2 * k + 1;

      assign conflict[k] = gate_in[H] & gate_in[L];

      assign q_next[H] = (gate_in[H] && !conflict[k]) ?
                         ((q[H] == QMAX) ? q[H] : q[H] + 8'd1) : 8'd0;
      assign q_next[L] = (gate_in[L] && !conflict[k]) ?
                         ((q[L] == QMAX) ? q[L] : q[L] + 8'd1) : 8'd0;

      // A side may stay on, but may only turn on while the opposite side is
      // neither requested nor driven.
      assign run_gate[H] = (q_next[H] == QMAX) &&
                           (gate_out[H] || (!gate_in[L] && !gate_out[L]));
      assign run_gate[L] = (q_next[L] == QMAX) &&
                           (gate_out[L] || (!gate_in[H] && !gate_out[H]));
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: outputs sit inside the async reset so a reset mid-RUN removes gate
      // drive without waiting for a clock edge; counters clear with them.
      if (reset) begin
         st            <= ST_OFF;
         cnt           <= '0;
         q             <= '0;
         gate_out      <= '0;
         fault_latched <= 1'b0;
         shoot_through <= 1'b0;
      end else begin
         q <= stay_run ? q_next : '0;
         if (|conflict) shoot_through <= 1'b1;

         case (st)
            ST_OFF: begin
               gate_out      <= '0;
               fault_latched <= 1'b0;
               if (enable && !fault_in) begin
                  st       <= ST_PRECHARGE;
                  cnt      <= PRE_LOAD;
                  gate_out <= LOW_SIDES;
               end
            end

            ST_PRECHARGE: begin
               if (fault_in) begin
                  st            <= ST_FAULT;
                  cnt           <= HOLD_LOAD;
                  gate_out      <= '0;
                  fault_latched <= 1'b1;
               end else if (!enable) begin
                  st       <= ST_OFF;
                  gate_out <= '0;
               end else if (cnt == '0) begin
                  st       <= ST_RUN;
                  gate_out <= '0;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end

            ST_RUN: begin
               if (fault_in) begin
                  st            <= ST_FAULT;
                  cnt           <= HOLD_LOAD;
                  gate_out      <= '0;
                  fault_latched <= 1'b1;
               end else if (!enable) begin
                  st       <= ST_OFF;
                  gate_out <= '0;
               end else begin
                  gate_out <= run_gate;
               end
            end

            ST_FAULT: begin
               gate_out      <= '0;
               fault_latched <= 1'b1;
               // A repeated fault restarts the hold-off from the beginning.
               if (fault_in) begin
                  cnt <= HOLD_LOAD;
               end else if (cnt != '0) begin
                  cnt <= cnt - 16'd1;
               end else if (clear) begin
                  st            <= ST_OFF;
                  fault_latched <= 1'b0;
               end
            end

            default: begin
               st       <= ST_OFF;
               gate_out <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ac_motor_gate_guard.sv
// Bench for ac_motor_gate_guard: per-cycle expected outputs are queued as stimulus
// is applied and popped for comparison after each clock edge.
module tb_ac_motor_gate_guard;

   localparam int MIN_ON     = 20;
   localparam int PRECHARGE  = 1000;
   localparam int FAULT_HOLD = 10000;
   localparam int DT         = 4;
   localparam logic [5:0] LOW_SIDES = 6'b101010;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       fault_in;
   logic       clear;
   logic [5:0] gate_in;
   logic [5:0] gate_out;
   logic [1:0] state;
   logic       fault_latched;
   logic       shoot_through;
   logic [9:0] obs;

   ac_motor_gate_guard #(
      .MIN_ON    (MIN_ON),
      .PRECHARGE (PRECHARGE),
      .FAULT_HOLD(FAULT_HOLD)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .fault_in     (fault_in),
      .clear        (clear),
      .gate_in      (gate_in),
      .gate_out     (gate_out),
      .state        (state),
      .fault_latched(fault_latched),
      .shoot_through(shoot_through)
   );

   always #5 clk = ~clk;

   assign obs = {gate_out, state, fault_latched, shoot_through};

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [9:0] sb[$];

   // Filter model: consecutive-high count per bit, interlock on turn-on.
   int         consec[6];
   logic [5:0] m_gate;
   logic       m_sticky;

   function automatic logic [9:0] mk(input logic [5:0] g, input logic [1:0] s, input logic fl);
      return {g, s, fl, m_sticky};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic [5:0] gin, input logic [9:0] e);
      sb.push_back(e);
      gate_in = gin;
      tick();
   endtask

   task automatic model_clear();
      for (int i = 0; i < 6; i++) consec[i] = 0;
      m_gate = '0;
   endtask

   task automatic model_step(input logic [5:0] gin, output logic [5:0] eg);
      logic [5:0] ng;
      ng = '0;
      for (int k = 0; k < 3; k++) begin
         int   h;
         int   l;
         logic both;
         h    = 2 * k;
         l    = h + 1;
         both = gin[h] & gin[l];
         if (both) m_sticky = 1'b1;
         consec[h] = (gin[h] && !both) ? consec[h] + 1 : 0;
         consec[l] = (gin[l] && !both) ? consec[l] + 1 : 0;
         ng[h] = (consec[h] >= MIN_ON) && (m_gate[h] || (!gin[l] && !m_gate[l]));
         ng[l] = (consec[l] >= MIN_ON) && (m_gate[l] || (!gin[h] && !m_gate[h]));
      end
      m_gate = ng;
      eg     = ng;
   endtask

   task automatic run_cycle(input logic [5:0] gin);
      logic [5:0] eg;
      model_step(gin, eg);
      apply(gin, mk(eg, 2'd2, 1'b0));
   endtask

   task automatic test_reset();
      logic [9:0] e;
      reset = 1'b1; enable = 1'b0; fault_in = 1'b0; clear = 1'b0; gate_in = '0;
      m_sticky = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (obs !== 10'b0) begin
         n_fail++;
         $display("FAIL reset_state: got %b expected %b", obs, 10'b0);
      end
      reset = 1'b0;
      apply(6'b0, mk(6'b0, 2'd0, 1'b0));
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL reset_release_idle: got %b expected %b", obs, e);
      end
   endtask

   task automatic test_startup();
      logic [9:0] e;
      enable = 1'b1;
      for (int k = 0; k <= PRECHARGE; k++) begin
         apply(6'b0, (k < PRECHARGE) ? mk(LOW_SIDES, 2'd1, 1'b0) : mk(6'b0, 2'd2, 1'b0));
         e = sb.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL startup edge %0d: got %b expected %b", k, obs, e);
         end
      end
      model_clear();
   endtask

   task automatic test_pulse_filter();
      logic [9:0] e;
      logic [5:0] seg_g[6];
      int         seg_n[6];
      int         hi0[6];
      int         first0[6];
      int         hi5[6];
      int         first5[6];
      seg_g = '{6'b000001, 6'b000000, 6'b000001, 6'b000000, 6'b100000, 6'b000000};
      seg_n = '{19, 6, 40, 6, 20, 4};
      for (int s = 0; s < 6; s++) begin
         hi0[s] = 0; first0[s] = -1; hi5[s] = 0; first5[s] = -1;
         for (int c = 0; c < seg_n[s]; c++) begin
            run_cycle(seg_g[s]);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
               n_fail++;
               $display("FAIL pulse seg %0d cyc %0d: got %b expected %b", s, c, obs, e);
            end
            if (gate_out[0]) begin
               hi0[s]++;
               if (first0[s] < 0) first0[s] = c;
            end
            if (gate_out[5]) begin
               hi5[s]++;
               if (first5[s] < 0) first5[s] = c;
            end
         end
      end
      n_checks++;
      if (hi0[0] !== 0) begin
         n_fail++;
         $display("FAIL short_pulse_width: got %0d expected 0", hi0[0]);
      end
      n_checks++;
      if (hi0[2] !== 21) begin
         n_fail++;
         $display("FAIL long_pulse_width: got %0d expected 21", hi0[2]);
      end
      n_checks++;
      if (first0[2] !== MIN_ON - 1) begin
         n_fail++;
         $display("FAIL long_pulse_delay: got %0d expected %0d", first0[2], MIN_ON - 1);
      end
      n_checks++;
      if (hi0[3] !== 0) begin
         n_fail++;
         $display("FAIL turn_off_latency: got %0d expected 0", hi0[3]);
      end
      n_checks++;
      if (hi5[4] !== 1 || first5[4] !== MIN_ON - 1) begin
         n_fail++;
         $display("FAIL exact_min_pulse: got width %0d at %0d expected 1 at %0d",
                  hi5[4], first5[4], MIN_ON - 1);
      end
   endtask

   task automatic test_interlock();
      logic [9:0] e;
      logic [5:0] seg_g[4];
      int         seg_n[4];
      int         gap;
      seg_g = '{6'b000100, 6'b001000, 6'b000100, 6'b000000};
      seg_n = '{30, 30, 25, 3};
      gap   = 0;
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < seg_n[s]; c++) begin
            run_cycle(seg_g[s]);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
               n_fail++;
               $display("FAIL interlock seg %0d cyc %0d: got %b expected %b", s, c, obs, e);
            end
            if (s == 1 && gate_out[3:2] == 2'b00) gap++;
         end
      end
      n_checks++;
      if (gap !== MIN_ON - 1) begin
         n_fail++;
         $display("FAIL handover_gap: got %0d expected %0d", gap, MIN_ON - 1);
      end
   endtask

   task automatic test_full_chain();
      logic [9:0] e;
      logic [5:0] gin;
      logic       ref_v[3];
      logic       r;
      logic       h;
      logic       l;
      int         since[3];
      int         half[3];
      int         lowgap[3];
      int         last_side[3];
      int         side;
      int         n_gap;
      half  = '{30, 37, 45};
      n_gap = 0;
      for (int k = 0; k < 3; k++) begin
         since[k] = 0; lowgap[k] = 0; last_side[k] = -1; ref_v[k] = 1'b0;
      end
      for (int cyc = 0; cyc < 480; cyc++) begin
         gin = '0;
         for (int k = 0; k < 3; k++) begin
            r = ((cyc / half[k]) % 2) == 0;
            if (cyc == 0 || r != ref_v[k]) since[k] = 1;
            else since[k]++;
            ref_v[k]      = r;
            gin[2 * k]     = r && (since[k] > DT);
            gin[2 * k + 1] = !r && (since[k] > DT);
         end
         run_cycle(gin);
         e = sb.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL chain cyc %0d: got %b expected %b", cyc, obs, e);
         end
         for (int k = 0; k < 3; k++) begin
            h = gate_out[2 * k];
            l = gate_out[2 * k + 1];
            n_checks++;
            if (h && l) begin
               n_fail++;
               $display("FAIL chain_overlap phase %0d cyc %0d: got %b expected not 11", k + 1, cyc, {l, h});
            end
            if (!h && !l) begin
               lowgap[k]++;
            end else begin
               side = h ? 0 : 1;
               if (last_side[k] >= 0 && last_side[k] != side) begin
                  n_gap++;
                  n_checks++;
                  if (lowgap[k] < DT + MIN_ON - 1) begin
                     n_fail++;
                     $display("FAIL chain_dead_time phase %0d cyc %0d: got %0d expected >= %0d",
                              k + 1, cyc, lowgap[k], DT + MIN_ON - 1);
                  end
               end
               last_side[k] = side;
               lowgap[k]    = 0;
            end
         end
      end
      n_checks++;
      if (n_gap < 6) begin
         n_fail++;
         $display("FAIL chain_gap_count: got %0d expected >= 6", n_gap);
      end
      for (int c = 0; c < 3; c++) begin
         run_cycle(6'b0);
         e = sb.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL chain_drain cyc %0d: got %b expected %b", c, obs, e);
         end
      end
   endtask

   task automatic test_disable();
      logic [9:0] e;
      for (int c = 0; c < 25; c++) begin
         run_cycle(6'b010000);
         e = sb.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL disable_pre cyc %0d: got %b expected %b", c, obs, e);
         end
      end
      enable = 1'b0;
      apply(6'b010000, mk(6'b0, 2'd0, 1'b0));
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL disable_drop: got %b expected %b", obs, e);
      end
      model_clear();
      apply(6'b0, mk(6'b0, 2'd0, 1'b0));
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL disable_stay_off: got %b expected %b", obs, e);
      end
   endtask

   task automatic test_fault();
      logic [9:0] e;
      for (int c = 0; c < 25; c++) begin
         run_cycle(6'b000010);
         e = sb.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL fault_pre cyc %0d: got %b expected %b", c, obs, e);
         end
      end
      fault_in = 1'b1;
      clear    = 1'b1;
      apply(6'b000010, mk(6'b0, 2'd3, 1'b1));
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL fault_entry: got %b expected %b", obs, e);
      end
      fault_in = 1'b0;
      for (int j = 1; j <= FAULT_HOLD; j++) begin
         apply(6'b000010, (j < FAULT_HOLD) ? mk(6'b0, 2'd3, 1'b1) : mk(6'b0, 2'd0, 1'b0));
         e = sb.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL fault_hold cyc %0d: got %b expected %b", j, obs, e);
         end
      end
      enable = 1'b0;
      clear  = 1'b0;
      model_clear();
      apply(6'b0, mk(6'b0, 2'd0, 1'b0));
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL fault_off_idle: got %b expected %b", obs, e);
      end
   endtask

   task automatic test_fault_reload();
      logic [9:0] e;
      enable = 1'b1;
      clear  = 1'b1;
      for (int k = 0; k < 6; k++) begin
         apply(6'b0, mk(LOW_SIDES, 2'd1, 1'b0));
         e = sb.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL reload_precharge cyc %0d: got %b expected %b", k, obs, e);
         end
      end
      fault_in = 1'b1;
      apply(6'b0, mk(6'b0, 2'd3, 1'b1));
      fault_in = 1'b0;
      for (int j = 1; j < 100; j++) apply(6'b0, mk(6'b0, 2'd3, 1'b1));
      fault_in = 1'b1;
      apply(6'b0, mk(6'b0, 2'd3, 1'b1));
      fault_in = 1'b0;
      for (int j = 1; j <= FAULT_HOLD; j++)
         apply(6'b0, (j < FAULT_HOLD) ? mk(6'b0, 2'd3, 1'b1) : mk(6'b0, 2'd0, 1'b0));
      enable = 1'b0;
      clear  = 1'b0;
      apply(6'b0, mk(6'b0, 2'd0, 1'b0));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         if (obs !== e && sb.size() == 0) begin
            n_fail++;
            $display("FAIL reload_final: got %b expected %b", obs, e);
         end
      end
   endtask

   task automatic test_shoot_through();
      logic [9:0] e;
      for (int c = 0; c < 57; c++) begin
         run_cycle((c < 30) ? 6'b000011 : ((c < 35) ? 6'b000000 : 6'b000001));
         e = sb.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL shoot cyc %0d: got %b expected %b", c, obs, e);
         end
      end
      n_checks++;
      if (shoot_through !== 1'b1) begin
         n_fail++;
         $display("FAIL shoot_sticky: got %b expected 1", shoot_through);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [9:0] e;
      for (int c = 0; c < 25; c++) begin
         run_cycle(6'b010000);
         e = sb.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_pre cyc %0d: got %b expected %b", c, obs, e);
         end
      end
      #3;
      reset = 1'b1;
      #1;
      n_checks++;
      if (obs !== 10'b0) begin
         n_fail++;
         $display("FAIL async_reset: got %b expected %b", obs, 10'b0);
      end
      enable  = 1'b0;
      gate_in = '0;
      tick();
      reset    = 1'b0;
      m_sticky = 1'b0;
      model_clear();
      apply(6'b0, mk(6'b0, 2'd0, 1'b0));
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL post_reset_idle: got %b expected %b", obs, e);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      test_reset();
      test_startup();
      test_pulse_filter();
      test_interlock();
      test_full_chain();
      test_disable();
      test_startup();
      test_fault();
      test_fault_reload();
      test_startup();
      test_shoot_through();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ac_motor_gate_guard.md
# ac_motor_gate_guard

Final protection stage of the AC motor inverter path. It sits directly downstream of the three switch-delay (dead-time) instances and consumes their six high/low gate commands. Before any signal reaches the gate drivers, it enforces:
- a hard shoot-through interlock,
- minimum on-pulse qualification,
- a bootstrap precharge sequence at start-up,
- a latched fault shutdown with a hold-off and an explicit clear.

## Interface
Parameters:
- MIN_ON, 20: consecutive cycles a gate command must be high before the output turns on. Legal range is 1..255.
- PRECHARGE, 1000: cycles all low-side switches are held on before RUN. Legal range is 1..65535.
- FAULT_HOLD, 10000: minimum cycles spent in FAULT before a clear is accepted. Legal range is 1..65535.

Ports:
- clk  in  1  system clock. One clock, and the block uses only this clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run request, level sensitive.
- fault_in  in  1  overcurrent/desat fault, active high.
- clear  in  1  fault acknowledge, level sampled.
- gate_in  in  6  commands from the switch-delay stages: {s3_low, s3_high, s2_low, s2_high, s1_low, s1_high}. Bit 2k is the phase k+1 high side; bit 2k+1 is the phase k+1 low side.
- gate_out  out  6  gate driver outputs, registered, same bit order as gate_in.
- state  out  2  0=OFF, 1=PRECHARGE, 2=RUN, 3=FAULT.
- fault_latched  out  1  high while state==FAULT.
- shoot_through  out  1  sticky flag, set when both sides of any phase were requested simultaneously.

## Operation
- Reset (asynchronous assert) sets all outputs to 0: gate_out=0, state=OFF, fault_latched=0, shoot_through=0. All counters clear. Reset asserted mid-RUN drops gate_out to 0 immediately, without waiting for a clock edge.
- FSM transitions, evaluated on each clk rising edge. Where several conditions hold at once, the priority is fault_in > enable low > counter expiry.
  - OFF: gate_out=0. If enable=1 and fault_in=0, go to PRECHARGE and load the counter with PRECHARGE-1.
  - PRECHARGE: gate_out=6'b101010 (all low sides on, all high sides off). The counter decrements; on the edge where the counter is 0, go to RUN. If enable=0, go to OFF. If fault_in=1, go to FAULT.
  - RUN: gate_out comes from the per-bit filter below. If enable=0, go to OFF. If fault_in=1, go to FAULT.
  - FAULT: gate_out=0 and fault_latched=1. The hold counter is loaded with FAULT_HOLD-1 on entry and decrements to 0. Go to OFF only when the counter is 0, clear=1 and fault_in=0. If fault_in is re-asserted during FAULT, the hold counter reloads.
- Per-bit filter (RUN only):
  - Each of the six bits has an 8-bit qualification counter q[i]. q[i] is 0 when gate_in[i]=0, otherwise it increments and saturates at MIN_ON.
  - The on-request for bit i is q[i]==MIN_ON.
  - In every state other than RUN, all q[i] are held at 0.
- Interlock, per phase k with high bit h and low bit l:
  - gate_out[h] may rise only if gate_in[l]=0 and gate_out[l]=0, and the same rule applies to l with respect to h.
  - If gate_in[h] and gate_in[l] are both 1 in the same cycle, both outputs go to 0, both counters clear, and shoot_through is set. shoot_through is cleared only by reset.
  - Turn-off is never delayed: gate_in[i]=0 forces gate_out[i]=0 on the next edge.
- Because the filter delays only turn-on, dead time from the upstream switch-delay stage is lengthened by MIN_ON-1 cycles and is never shortened.

## Timing
- Turn-off latency is 1 cycle: gate_in falls before edge t, and gate_out is 0 after edge t.
- Turn-on latency is MIN_ON cycles: gate_in is high from edge t onward, and gate_out rises after edge t+MIN_ON-1.
- An input pulse shorter than MIN_ON cycles produces no output pulse.
- Fault latency is 1 cycle: fault_in sampled high at edge t gives gate_out=0 and state=FAULT after edge t. fault_in has no synchronizer; it must arrive already synchronous to clk.
- Entering RUN from OFF takes exactly PRECHARGE+1 edges, counted from the first edge that samples enable=1.
- The minimum time spent in FAULT is FAULT_HOLD cycles.
- A RUN-to-OFF transition (enable=0) drops gate_out to 0 on the same edge.

## Test plan
1. Start-up, with MIN_ON=20 and PRECHARGE=1000.
   - Stimulus: enable goes high at edge 0.
   - Required response: state=1 and gate_out=6'b101010 for 1000 cycles, then state=2 after edge 1000.
2. Pulse filtering.
   - Stimulus: in RUN, drive gate_in[0] high for 19 cycles, then drive it high for 40 cycles.
   - Required response: the 19-cycle pulse gives gate_out[0]=0 throughout. The 40-cycle pulse gives gate_out[0] high for 21 cycles, starting 20 edges after the rise and falling 1 edge after the input falls.
3. Shoot-through.
   - Stimulus: gate_in=6'b000011 for 30 cycles.
   - Required response: gate_out[1:0]=0 throughout, and shoot_through=1 from the first cycle and remains set afterwards.
4. Fault, with FAULT_HOLD=10000.
   - Stimulus: pulse fault_in for 1 cycle mid-RUN, hold clear=1 from then on.
   - Required response: gate_out=0 on the next edge and state=3. state returns to 0 exactly 10000 cycles later. A clear asserted before that has no effect.
5. Reset mid-RUN.
   - Stimulus: assert reset asynchronously between edges.
   - Required response: gate_out=0 and state=0 immediately, with shoot_through=0 and fault_latched=0.
6. Full chain.
   - Stimulus: connect this block to the three switch-delay outputs with the motor control at full power.
   - Required response: no phase ever shows both gate_out bits high in the same cycle, and every high/low gap is at least the upstream delay plus MIN_ON-1 cycles.
